rtc_set_ctrl: RTL and testbench
===============================

// Module: rtc_set_ctrl
// PURPOSE
//  Sequences host "set time" requests into the RTC second/minute/hour/date/month counters.
//  Validates the request, freezes the counters, loads all fields atomically, then releases them.
//  Sits between the host register interface and the RTC counter chain.
//  The RTC counter chain honours rtc_hold (ignore ticks) and rtc_load (parallel load).
// PARAMETERS
//  GUARD_CYC  2  clk cycles rtc_hold is held with no rtc_tick seen before the load; range 1..15
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  req_valid    in   1  host set-time request
//  req_ready    out  1  request can be accepted
//  req_sec      in   6  seconds, 0..59
//  req_min      in   6  minutes, 0..59
//  req_hour     in   5  hours, 0..23
//  req_date     in   5  day of month, 1..days_in_month(req_month)
//  req_month    in   4  month, 1..12
//  rtc_tick     in   1  1-cycle seconds-tick pulse from the prescaler, synchronous to clk
//  rtc_hold     out  1  freeze RTC counters
//  rtc_load     out  1  1-cycle parallel-load strobe
//  load_sec/min/hour/date/month  out  6/6/5/5/4  captured fields, valid while rtc_load=1
//  done         out  1  1-cycle pulse: load completed
//  err          out  1  1-cycle pulse: request rejected as out of range
//  cur_sec/min/hour  in  6/6/5  live RTC time (ALARM_EN only)
//  alarm_wr     in   1  write alarm_sec/min/hour and arm the alarm (ALARM_EN only)
//  alarm_sec/min/hour  in  6/6/5  alarm time (ALARM_EN only)
//  alarm_clr    in   1  clear alarm_irq (ALARM_EN only)
//  alarm_irq    out  1  sticky alarm flag (ALARM_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; all other outputs and capture regs 0; alarm disarmed.
//  FSM: IDLE -> CHECK -> (IDLE | HOLD) ; HOLD -> LOAD -> DONE -> IDLE.
//  IDLE: req_ready=1. Handshake: req_valid&&req_ready captures all req_* fields; next state is CHECK.
//  Not IDLE: req_ready=0. A req_valid seen while busy is not captured; the host keeps it asserted.
//  CHECK (1 cycle): any field out of range -> err=1 for this cycle, then IDLE.
//    Days per month are 31,28,31,30,31,30,31,31,30,31,30,31; there is no leap-year handling.
//  CHECK, valid request: next state is HOLD; rtc_hold=1 from the first HOLD cycle until the DONE cycle inclusive.
//  HOLD: a 4-bit guard counter increments each cycle with rtc_tick=0.
//    rtc_tick=1 resets the counter to 0.
//    The tick is dropped, because the loaded time supersedes it.
//    The FSM leaves for LOAD in the cycle where the count reaches GUARD_CYC.
//  LOAD (1 cycle): rtc_load=1; load_* = captured fields.
//  DONE (1 cycle): done=1; rtc_hold=1 this cycle, 0 from the next cycle; then IDLE.
//  Latency, valid request with no tick: accept -> done = 3+GUARD_CYC cycles (5 at default).
//  Latency, invalid request: accept -> err = 1 cycle.
//  rst_n low mid-sequence: immediate return to reset values.
//    rtc_hold and rtc_load drop asynchronously; no partial load is possible.
//  load_* are held at 0 outside LOAD.
// CONFIGURATION
//  ALARM_EN defined: alarm_wr latches alarm_* and sets armed=1.
//    match = armed && cur_* == alarm_*.
//    Rising edge of match (registered) sets alarm_irq.
//    alarm_clr clears alarm_irq; set wins if set and clear occur in the same cycle.
//    Match is masked while rtc_hold=1.
//  ALARM_EN undefined: alarm_irq tied 0; cur_*, alarm_* and alarm_clr are unused; no alarm registers exist.
// STRUCTURE
//  rtc_pkg: field widths, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12.
//  rtc_pkg: state enum {IDLE,CHECK,HOLD,LOAD,DONE}.
//  rtc_pkg: days_in_month(month) function.
//  One sub-module, rtc_time_check: combinational range validator that returns a valid flag.
// TESTING
//  1. Reset, then request 23:59:59 31/12 with no ticks -> rtc_hold rises at +2 cycles.
//     rtc_load with those values at +4; done at +5; req_ready=1 at +6.
//  2. Request sec=60 -> err pulse 1 cycle after accept; rtc_hold and rtc_load never assert.
//  3. Request date=29 month=2 -> err pulse. Request date=30 month=4 -> accepted and loaded.
//  4. Inject rtc_tick in the 2nd HOLD cycle -> guard restarts; rtc_load is delayed by 2 cycles (GUARD_CYC=2).
//  5. Deassert rst_n during HOLD -> rtc_hold=0 immediately, no rtc_load, req_ready=1 after release.
//  6. ALARM_EN: alarm 00:00:05, drive cur 00:00:04 then 00:00:05 -> alarm_irq=1 the cycle after the match.
//     Stays set through 00:00:06; alarm_clr clears it.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC set-time controller.
//   Field widths and range limits for seconds/minutes/hours/date/month,
//   the sequencer state enumeration and a days-per-month lookup.
//   Leap years are not modelled: February always has 28 days.
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DATE_W  = 5;
  localparam int MONTH_W = 4;

  localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
  localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
  localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    HOLD  = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Number of days in a month; an illegal month yields 0 so that no date passes.
  function automatic logic [DATE_W-1:0] days_in_month(input logic [MONTH_W-1:0] month);
    logic [DATE_W-1:0] days;
    case (month)
      4'd2:                                    days = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:                 days = 5'd30;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days = 5'd31;
      default:                                 days = 5'd0;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/rtc_set_ctrl_if.sv
// rtc_set_ctrl_if: host request channel of the RTC set-time controller.
//   req_valid / req_ready        request handshake
//   req_sec/min/hour/date/month  requested time and date fields
//   done                         1-cycle pulse, load completed
//   err                          1-cycle pulse, request rejected
// master: host side; slave: controller side.
interface rtc_set_ctrl_if;
  import rtc_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [SEC_W-1:0]   req_sec;
  logic [MIN_W-1:0]   req_min;
  logic [HOUR_W-1:0]  req_hour;
  logic [DATE_W-1:0]  req_date;
  logic [MONTH_W-1:0] req_month;
  logic               done;
  logic               err;

  modport master (
    output req_valid, req_sec, req_min, req_hour, req_date, req_month,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_sec, req_min, req_hour, req_date, req_month,
    output req_ready, done, err
  );

endinterface

// File: rtl/rtc_time_check.sv
// rtc_time_check: combinational range validator for a set-time request.
//   sec, min, hour, date, month  in   candidate fields
//   valid                        out  1 when every field is in range
//                                     (date checked against its month)
module rtc_time_check
  import rtc_pkg::*;
(
  input  logic [SEC_W-1:0]   sec,
  input  logic [MIN_W-1:0]   min,
  input  logic [HOUR_W-1:0]  hour,
  input  logic [DATE_W-1:0]  date,
  input  logic [MONTH_W-1:0] month,
  output logic               valid
);

  // All-fields range check; an illegal month makes days_in_month 0, failing any date.
  always_comb begin
    valid = (sec <= SEC_MAX) && (min <= MIN_MAX) && (hour <= HOUR_MAX) &&
            (month != 4'd0) && (month <= MONTH_MAX) &&
            (date != 5'd0) && (date <= days_in_month(month));
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: sequences host "set time" requests into the RTC counter chain.
//   A request is captured in IDLE, range-checked (err pulse if bad), then the
//   counters are frozen (rtc_hold) until GUARD_CYC tick-free cycles have passed,
//   loaded in one strobe (rtc_load + load_*), and released after a done pulse.
// Parameters:
//   GUARD_CYC  tick-free hold cycles required before the load (1..15)
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req                          host request channel (rtc_set_ctrl_if.slave)
//   rtc_tick                     1-cycle seconds tick from the prescaler
//   rtc_hold, rtc_load           counter freeze and parallel-load strobe
//   load_sec/min/hour/date/month load values, non-zero only with rtc_load
//   cur_sec/min/hour             live RTC time (alarm only)
//   alarm_wr, alarm_sec/min/hour write and arm the alarm (alarm only)
//   alarm_clr, alarm_irq         clear / sticky alarm flag (alarm only)
// Build option: define ALARM_EN to include the alarm comparator; otherwise
// alarm_irq is tied low and the alarm/cur inputs are ignored.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rtc_set_ctrl_if.slave      req,
  input  logic               rtc_tick,
  output logic               rtc_hold,
  output logic               rtc_load,
  output logic [SEC_W-1:0]   load_sec,
  output logic [MIN_W-1:0]   load_min,
  output logic [HOUR_W-1:0]  load_hour,
  output logic [DATE_W-1:0]  load_date,
  output logic [MONTH_W-1:0] load_month,
  input  logic [SEC_W-1:0]   cur_sec,
  input  logic [MIN_W-1:0]   cur_min,
  input  logic [HOUR_W-1:0]  cur_hour,
  input  logic               alarm_wr,
  input  logic [SEC_W-1:0]   alarm_sec,
  input  logic [MIN_W-1:0]   alarm_min,
  input  logic [HOUR_W-1:0]  alarm_hour,
  input  logic               alarm_clr,
  output logic               alarm_irq
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_CHECK = CHECK;
  localparam logic [2:0] S_HOLD  = HOLD;
  localparam logic [2:0] S_LOAD  = LOAD;
  localparam logic [2:0] S_DONE  = DONE;

  localparam logic [3:0] GUARD_LIM = 4'(GUARD_CYC);

  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  logic [3:0]         guard_r;
  logic [3:0]         guard_inc_s;
  logic               accept_s;
  logic               req_ok_s;
  logic               cap_ok_r;
  logic [SEC_W-1:0]   cap_sec_r;
  logic [MIN_W-1:0]   cap_min_r;
  logic [HOUR_W-1:0]  cap_hour_r;
  logic [DATE_W-1:0]  cap_date_r;
  logic [MONTH_W-1:0] cap_month_r;
  logic               req_ready_r;
  logic               done_r;
  logic               err_r;
  logic               rtc_hold_r;
  logic               rtc_load_r;
  logic [SEC_W-1:0]   load_sec_r;
  logic [MIN_W-1:0]   load_min_r;
  logic [HOUR_W-1:0]  load_hour_r;
  logic [DATE_W-1:0]  load_date_r;
  logic [MONTH_W-1:0] load_month_r;

  // req_ready_r is high exactly in IDLE, so it doubles as the accept qualifier.
  assign accept_s = req.req_valid && req_ready_r;

  // The live request fields are validated at accept time; the verdict is stored
  // with the capture so CHECK can act on it in its single cycle.
  rtc_time_check u_time_check (
    .sec   (req.req_sec),
    .min   (req.req_min),
    .hour  (req.req_hour),
    .date  (req.req_date),
    .month (req.req_month),
    .valid (req_ok_s)
  );

  // Next-state decode of the set-time sequencer.
  always_comb begin
    state_nxt_s = state_r;
    guard_inc_s = guard_r + 4'd1;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = S_CHECK;
        else          state_nxt_s = S_IDLE;
      end
      S_CHECK: begin
        if (cap_ok_r) state_nxt_s = S_HOLD;
        else          state_nxt_s = S_IDLE;
      end
      S_HOLD: begin
        if (!rtc_tick && (guard_inc_s == GUARD_LIM)) state_nxt_s = S_LOAD;
        else                                          state_nxt_s = S_HOLD;
      end
      S_LOAD:  state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Guard counter: counts tick-free HOLD cycles; a tick restarts it and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_r <= 4'd0;
    end else if (state_r == S_HOLD) begin
      if (rtc_tick) guard_r <= 4'd0;
      else          guard_r <= guard_inc_s;
    end else begin
      guard_r <= 4'd0;
    end
  end

  // Request capture; only updated on an accepted handshake, so a request held
  // up by the host while busy is never sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_ok_r    <= 1'b0;
      cap_sec_r   <= 6'd0;
      cap_min_r   <= 6'd0;
      cap_hour_r  <= 5'd0;
      cap_date_r  <= 5'd0;
      cap_month_r <= 4'd0;
    end else if (accept_s) begin
      cap_ok_r    <= req_ok_s;
      cap_sec_r   <= req.req_sec;
      cap_min_r   <= req.req_min;
      cap_hour_r  <= req.req_hour;
      cap_date_r  <= req.req_date;
      cap_month_r <= req.req_month;
    end else begin
      cap_ok_r    <= cap_ok_r;
      cap_sec_r   <= cap_sec_r;
      cap_min_r   <= cap_min_r;
      cap_hour_r  <= cap_hour_r;
      cap_date_r  <= cap_date_r;
      cap_month_r <= cap_month_r;
    end
  end

  // Registered outputs, decoded from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r  <= 1'b1;
      err_r        <= 1'b0;
      done_r       <= 1'b0;
      rtc_hold_r   <= 1'b0;
      rtc_load_r   <= 1'b0;
      load_sec_r   <= 6'd0;
      load_min_r   <= 6'd0;
      load_hour_r  <= 5'd0;
      load_date_r  <= 5'd0;
      load_month_r <= 4'd0;
    end else begin
      req_ready_r  <= (state_nxt_s == S_IDLE);
      err_r        <= accept_s && !req_ok_s;
      done_r       <= (state_nxt_s == S_DONE);
      rtc_hold_r   <= (state_nxt_s == S_HOLD) || (state_nxt_s == S_LOAD) ||
                      (state_nxt_s == S_DONE);
      rtc_load_r   <= (state_nxt_s == S_LOAD);
      load_sec_r   <= (state_nxt_s == S_LOAD) ? cap_sec_r   : 6'd0;
      load_min_r   <= (state_nxt_s == S_LOAD) ? cap_min_r   : 6'd0;
      load_hour_r  <= (state_nxt_s == S_LOAD) ? cap_hour_r  : 5'd0;
      load_date_r  <= (state_nxt_s == S_LOAD) ? cap_date_r  : 5'd0;
      load_month_r <= (state_nxt_s == S_LOAD) ? cap_month_r : 4'd0;
    end
  end

  assign req.req_ready = req_ready_r;
  assign req.done      = done_r;
  assign req.err       = err_r;
  assign rtc_hold      = rtc_hold_r;
  assign rtc_load      = rtc_load_r;
  assign load_sec      = load_sec_r;
  assign load_min      = load_min_r;
  assign load_hour     = load_hour_r;
  assign load_date     = load_date_r;
  assign load_month    = load_month_r;

`ifdef ALARM_EN
  logic               armed_r;
  logic [SEC_W-1:0]   al_sec_r;
  logic [MIN_W-1:0]   al_min_r;
  logic [HOUR_W-1:0]  al_hour_r;
  logic               match_s;
  logic               match_r;
  logic               irq_r;

  // Alarm time register; a write also arms the comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r   <= 1'b0;
      al_sec_r  <= 6'd0;
      al_min_r  <= 6'd0;
      al_hour_r <= 5'd0;
    end else if (alarm_wr) begin
      armed_r   <= 1'b1;
      al_sec_r  <= alarm_sec;
      al_min_r  <= alarm_min;
      al_hour_r <= alarm_hour;
    end else begin
      armed_r   <= armed_r;
      al_sec_r  <= al_sec_r;
      al_min_r  <= al_min_r;
      al_hour_r <= al_hour_r;
    end
  end

  // Time match; ignored while the counters are frozen for a set-time load.
  always_comb begin
    match_s = armed_r && !rtc_hold_r && (cur_sec == al_sec_r) &&
              (cur_min == al_min_r) && (cur_hour == al_hour_r);
  end

  // Sticky flag set on the rising edge of match; set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      match_r <= match_s;
      if (match_s && !match_r) irq_r <= 1'b1;
      else if (alarm_clr)      irq_r <= 1'b0;
      else                     irq_r <= irq_r;
    end
  end

  assign alarm_irq = irq_r;
`else
  // Alarm inputs have no function in this build; reduce them into one sink.
  logic unused_alarm_s;
  assign unused_alarm_s = ^{cur_sec, cur_min, cur_hour, alarm_wr, alarm_sec,
                            alarm_min, alarm_hour, alarm_clr};
  assign alarm_irq = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// tb_rtc_set_ctrl: self-checking bench for rtc_set_ctrl (GUARD_CYC=2).
// Inputs are driven and outputs sampled on the falling clock edge. Cycle 0 is
// the cycle in which the request is offered; cycle c is c clocks later.
module tb_rtc_set_ctrl;

  localparam int G = 2;
`ifdef ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rtc_tick = 1'b0;
  logic       rtc_hold, rtc_load;
  logic [5:0] load_sec, load_min;
  logic [4:0] load_hour, load_date;
  logic [3:0] load_month;
  logic [5:0] cur_sec = 6'd0, cur_min = 6'd0, alarm_sec = 6'd0, alarm_min = 6'd0;
  logic [4:0] cur_hour = 5'd0, alarm_hour = 5'd0;
  logic       alarm_wr = 1'b0, alarm_clr = 1'b0;
  logic       alarm_irq;

  rtc_set_ctrl_if req_if();

  rtc_set_ctrl #(.GUARD_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_if), .rtc_tick(rtc_tick),
    .rtc_hold(rtc_hold), .rtc_load(rtc_load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .load_date(load_date), .load_month(load_month),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .alarm_wr(alarm_wr), .alarm_sec(alarm_sec), .alarm_min(alarm_min),
    .alarm_hour(alarm_hour), .alarm_clr(alarm_clr), .alarm_irq(alarm_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int dim [13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
  logic [63:0] tick_mask;

  // observed event cycles (-1 = never) and counts for the last request
  int o_err_first, o_err_n, o_hold_first, o_hold_n, o_load_first, o_load_n;
  int o_done_first, o_ready, o_leak;
  logic [25:0] o_load_val;
  // reference expectations
  bit e_ok;
  int e_err_first, e_hold_first, e_hold_n, e_load, e_done, e_ready;
  logic [25:0] e_val;

  // Reference: legality from calendar rules; load follows the first window of
  // G consecutive tick-free cycles starting at or after the first hold cycle (2).
  function automatic void model(input logic [5:0] s, input logic [5:0] m,
                                input logic [4:0] h, input logic [4:0] d,
                                input logic [3:0] mo);
    bit date_ok;
    bit quiet;
    int c;
    date_ok = 1'b0;
    if (mo >= 4'd1 && mo <= 4'd12) date_ok = (d >= 5'd1) && (int'(d) <= dim[mo]);
    e_ok  = (s < 6'd60) && (m < 6'd60) && (h < 5'd24) && date_ok;
    e_val = {s, m, h, d, mo};
    if (!e_ok) begin
      e_err_first = 1; e_hold_first = -1; e_hold_n = 0;
      e_load = -1; e_done = -1; e_ready = 2;
    end else begin
      for (c = G + 1; c < 60; c++) begin
        quiet = 1'b1;
        for (int k = c - G + 1; k <= c; k++) if (tick_mask[k]) quiet = 1'b0;
        if (quiet) break;
      end
      e_err_first = -1; e_hold_first = 2; e_hold_n = c + 1;
      e_load = c + 1; e_done = c + 2; e_ready = c + 3;
    end
  endfunction

  // Offer one request and record every output event until req_ready returns.
  // keep=1 leaves req_valid high (with scrambled fields) while the DUT is busy.
  task automatic drive_req(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                           input logic [4:0] d, input logic [3:0] mo, input bit keep);
    int w;
    w = 0;
    while (req_if.req_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    n_cmp++;
    if (req_if.req_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_before_request: got %b want 1", req_if.req_ready);
    end
    req_if.req_valid = 1'b1;
    req_if.req_sec = s; req_if.req_min = m; req_if.req_hour = h;
    req_if.req_date = d; req_if.req_month = mo;
    o_err_first = -1; o_err_n = 0; o_hold_first = -1; o_hold_n = 0;
    o_load_first = -1; o_load_n = 0; o_done_first = -1; o_ready = -1; o_leak = 0;
    o_load_val = 26'd0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (rtc_hold === 1'b1) begin if (o_hold_first < 0) o_hold_first = c; o_hold_n++; end
      if (rtc_load === 1'b1) begin
        if (o_load_first < 0) o_load_first = c;
        o_load_n++;
        o_load_val = {load_sec, load_min, load_hour, load_date, load_month};
      end else if ({load_sec, load_min, load_hour, load_date, load_month} !== 26'd0) begin
        o_leak++;
      end
      if (req_if.done === 1'b1 && o_done_first < 0) o_done_first = c;
      if (req_if.err === 1'b1) begin if (o_err_first < 0) o_err_first = c; o_err_n++; end
      req_if.req_valid = keep;
      req_if.req_sec = 6'($urandom); req_if.req_min = 6'($urandom);
      req_if.req_hour = 5'($urandom); req_if.req_date = 5'($urandom);
      req_if.req_month = 4'($urandom);
      rtc_tick = tick_mask[c];
      if (req_if.req_ready === 1'b1) begin o_ready = c; break; end
    end
    rtc_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_if.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_if.req_ready); end
    n_cmp++; if ({rtc_hold, rtc_load, req_if.done, req_if.err, alarm_irq} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000", {rtc_hold, rtc_load, req_if.done, req_if.err, alarm_irq});
    end
    n_cmp++; if ({load_sec, load_min, load_hour, load_date, load_month} !== 26'd0) begin
      n_err++; $display("FAIL reset_load_fields: got %h want 0", {load_sec, load_min, load_hour, load_date, load_month});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_if.req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_release: got %b want 1", req_if.req_ready); end
  endtask

  task automatic test_max_time();
    tick_mask = 64'd0;
    drive_req(6'd59, 6'd59, 5'd23, 5'd31, 4'd12, 1'b0);
    n_cmp++; if (o_hold_first !== 2) begin n_err++; $display("FAIL max_hold_rise: got %0d want 2", o_hold_first); end
    n_cmp++; if (o_load_first !== 4) begin n_err++; $display("FAIL max_load_cycle: got %0d want 4", o_load_first); end
    n_cmp++; if (o_load_val !== {6'd59, 6'd59, 5'd23, 5'd31, 4'd12}) begin
      n_err++; $display("FAIL max_load_value: got %h want %h", o_load_val, {6'd59, 6'd59, 5'd23, 5'd31, 4'd12});
    end
    n_cmp++; if (o_done_first !== 5) begin n_err++; $display("FAIL max_done_cycle: got %0d want 5", o_done_first); end
    n_cmp++; if (o_ready !== 6) begin n_err++; $display("FAIL max_ready_cycle: got %0d want 6", o_ready); end
    n_cmp++; if (o_hold_n !== 4) begin n_err++; $display("FAIL max_hold_len: got %0d want 4", o_hold_n); end
  endtask

  task automatic test_invalid_sec();
    tick_mask = 64'd0;
    drive_req(6'd60, 6'd0, 5'd0, 5'd1, 4'd1, 1'b0);
    n_cmp++; if (o_err_first !== 1 || o_err_n !== 1) begin
      n_err++; $display("FAIL sec60_err: got cycle %0d count %0d want cycle 1 count 1", o_err_first, o_err_n);
    end
    n_cmp++; if (o_hold_n !== 0 || o_load_n !== 0 || o_done_first !== -1) begin
      n_err++; $display("FAIL sec60_no_load: got hold %0d load %0d done %0d want 0 0 -1", o_hold_n, o_load_n, o_done_first);
    end
    n_cmp++; if (o_ready !== 2) begin n_err++; $display("FAIL sec60_ready: got %0d want 2", o_ready); end
  endtask

  task automatic test_month_days();
    tick_mask = 64'd0;
    drive_req(6'd0, 6'd0, 5'd0, 5'd29, 4'd2, 1'b0);
    n_cmp++; if (o_err_first !== 1 || o_load_n !== 0) begin
      n_err++; $display("FAIL feb29_err: got err %0d loads %0d want 1 0", o_err_first, o_load_n);
    end
    drive_req(6'd1, 6'd2, 5'd3, 5'd30, 4'd4, 1'b0);
    n_cmp++; if (o_err_n !== 0 || o_load_first !== 4) begin
      n_err++; $display("FAIL apr30_load: got err %0d load %0d want 0 4", o_err_n, o_load_first);
    end
    n_cmp++; if (o_load_val !== {6'd1, 6'd2, 5'd3, 5'd30, 4'd4}) begin
      n_err++; $display("FAIL apr30_value: got %h want %h", o_load_val, {6'd1, 6'd2, 5'd3, 5'd30, 4'd4});
    end
  endtask

  task automatic test_tick_guard();
    tick_mask = 64'd0;
    tick_mask[3] = 1'b1;
    drive_req(6'd10, 6'd20, 5'd5, 5'd15, 4'd6, 1'b0);
    n_cmp++; if (o_load_first !== 6) begin n_err++; $display("FAIL tick_load_delay: got %0d want 6", o_load_first); end
    n_cmp++; if (o_done_first !== 7 || o_hold_n !== 6) begin
      n_err++; $display("FAIL tick_done_hold: got done %0d hold %0d want 7 6", o_done_first, o_hold_n);
    end
    tick_mask = 64'd0;
  endtask

  task automatic test_reset_mid();
    int loads;
    int holds;
    loads = 0; holds = 0;
    req_if.req_valid = 1'b1;
    req_if.req_sec = 6'd0; req_if.req_min = 6'd0; req_if.req_hour = 5'd12;
    req_if.req_date = 5'd1; req_if.req_month = 4'd1;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rtc_hold !== 1'b1) begin n_err++; $display("FAIL midrst_in_hold: got %b want 1", rtc_hold); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rtc_hold !== 1'b0 || rtc_load !== 1'b0) begin
      n_err++; $display("FAIL midrst_async_drop: got hold %b load %b want 0 0", rtc_hold, rtc_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rtc_load === 1'b1) loads++;
      if (rtc_hold === 1'b1) holds++;
    end
    n_cmp++; if (loads !== 0 || holds !== 0) begin
      n_err++; $display("FAIL midrst_no_load: got loads %0d holds %0d want 0 0", loads, holds);
    end
    n_cmp++; if (req_if.req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", req_if.req_ready); end
  endtask

  task automatic test_random();
    logic [5:0] s, m;
    logic [4:0] h, d;
    logic [3:0] mo;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        s = 6'($urandom_range(0, 59)); m = 6'($urandom_range(0, 59));
        h = 5'($urandom_range(0, 23)); mo = 4'($urandom_range(1, 12));
        d = 5'($urandom_range(1, dim[mo]));
      end else begin
        s = 6'($urandom); m = 6'($urandom); h = 5'($urandom);
        d = 5'($urandom); mo = 4'($urandom);
      end
      tick_mask = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_0000_000F_FFFF;
      model(s, m, h, d, mo);
      drive_req(s, m, h, d, mo, 1'b0);
      n_cmp++; if (o_err_first !== e_err_first || o_err_n !== (e_ok ? 0 : 1)) begin
        n_err++; $display("FAIL rnd%0d_err: got %0d/%0d want %0d", i, o_err_first, o_err_n, e_err_first);
      end
      n_cmp++; if (o_hold_first !== e_hold_first || o_hold_n !== e_hold_n) begin
        n_err++; $display("FAIL rnd%0d_hold: got %0d/%0d want %0d/%0d", i, o_hold_first, o_hold_n, e_hold_first, e_hold_n);
      end
      n_cmp++; if (o_load_first !== e_load || o_load_n !== (e_ok ? 1 : 0)) begin
        n_err++; $display("FAIL rnd%0d_load_cycle: got %0d/%0d want %0d", i, o_load_first, o_load_n, e_load);
      end
      if (e_ok) begin
        n_cmp++; if (o_load_val !== e_val) begin
          n_err++; $display("FAIL rnd%0d_load_value: got %h want %h", i, o_load_val, e_val);
        end
      end
      n_cmp++; if (o_done_first !== e_done || o_ready !== e_ready) begin
        n_err++; $display("FAIL rnd%0d_done_ready: got %0d/%0d want %0d/%0d", i, o_done_first, o_ready, e_done, e_ready);
      end
      n_cmp++; if (o_leak !== 0) begin n_err++; $display("FAIL rnd%0d_load_leak: got %0d want 0", i, o_leak); end
    end
    tick_mask = 64'd0;
  endtask

  task automatic test_back_to_back();
    logic [25:0] reqs [3];
    reqs[0] = {6'd5, 6'd6, 5'd7, 5'd8, 4'd9};
    reqs[1] = {6'd0, 6'd0, 5'd0, 5'd31, 4'd11};
    reqs[2] = {6'd58, 6'd1, 5'd22, 5'd28, 4'd2};
    tick_mask = 64'd0;
    for (int i = 0; i < 3; i++) begin
      model(reqs[i][25:20], reqs[i][19:14], reqs[i][13:9], reqs[i][8:4], reqs[i][3:0]);
      drive_req(reqs[i][25:20], reqs[i][19:14], reqs[i][13:9], reqs[i][8:4], reqs[i][3:0], i < 2);
      n_cmp++; if (o_err_first !== e_err_first || o_load_n !== (e_ok ? 1 : 0)) begin
        n_err++; $display("FAIL b2b%0d_outcome: got err %0d loads %0d want err %0d", i, o_err_first, o_load_n, e_err_first);
      end
      if (e_ok) begin
        n_cmp++; if (o_load_val !== e_val) begin
          n_err++; $display("FAIL b2b%0d_value: got %h want %h", i, o_load_val, e_val);
        end
      end
      n_cmp++; if (o_ready !== e_ready) begin n_err++; $display("FAIL b2b%0d_ready: got %0d want %0d", i, o_ready, e_ready); end
    end
    req_if.req_valid = 1'b0;
  endtask

  task automatic test_alarm();
    @(negedge clk);
    alarm_wr = 1'b1; alarm_sec = 6'd5; alarm_min = 6'd0; alarm_hour = 5'd0;
    cur_sec = 6'd4; cur_min = 6'd0; cur_hour = 5'd0;
    @(negedge clk);
    alarm_wr = 1'b0;
    n_cmp++; if (alarm_irq !== 1'b0) begin n_err++; $display("FAIL alarm_before: got %b want 0", alarm_irq); end
    @(negedge clk);
    n_cmp++; if (alarm_irq !== 1'b0) begin n_err++; $display("FAIL alarm_at_04: got %b want 0", alarm_irq); end
    cur_sec = 6'd5;
    @(negedge clk);
    n_cmp++; if (alarm_irq !== ALARM_ON) begin n_err++; $display("FAIL alarm_match: got %b want %b", alarm_irq, ALARM_ON); end
    cur_sec = 6'd6;
    @(negedge clk);
    n_cmp++; if (alarm_irq !== ALARM_ON) begin n_err++; $display("FAIL alarm_sticky: got %b want %b", alarm_irq, ALARM_ON); end
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    n_cmp++; if (alarm_irq !== 1'b0) begin n_err++; $display("FAIL alarm_clear: got %b want 0", alarm_irq); end
  endtask

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_sec = 6'd0; req_if.req_min = 6'd0; req_if.req_hour = 5'd0;
    req_if.req_date = 5'd0; req_if.req_month = 4'd0;
    tick_mask = 64'd0;
    test_reset();
    test_max_time();
    test_invalid_sec();
    test_month_days();
    test_tick_guard();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_alarm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
